led_serializer: RTL and testbench

LED_SERIALIZER -- requirements
Module: led_serializer

---
 rtl/led_serializer_if.sv | 41 ++++
 rtl/led_serializer.sv | 131 +++++++++++++
 tb/tb_led_serializer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_serializer_if.sv
// Bundles the control inputs and status outputs of the LED serializer.
// The master side (stimulus or a controller) drives the requests and the
// parallel word; the slave side (the serializer) drives the display/status.
interface led_serializer_if;
    logic       load_re;
    logic       step_re;
    logic       auto_en;
    logic [7:0] switch_in;
    logic [7:0] led_output;
    logic       bit_out;
    logic [3:0] bits_left;
    logic       busy;
    logic       done;
    logic [7:0] segment_output;

    modport master (
        output load_re,
        output step_re,
        output auto_en,
        output switch_in,
        input  led_output,
        input  bit_out,
        input  bits_left,
        input  busy,
        input  done,
        input  segment_output
    );

    modport slave (
        input  load_re,
        input  step_re,
        input  auto_en,
        input  switch_in,
        output led_output,
        output bit_out,
        output bits_left,
        output busy,
        output done,
        output segment_output
    );
endinterface

// File: rtl/led_serializer.sv
// LED serializer: loads an 8-bit word and shifts it out MSB first, one bit
// per step. Steps come from manual pulses or, while auto_en is high, from a
// divided tick. The shift register is shown on the LEDs and the current bit
// on a 7-segment digit ("1" or "0"), with the decimal point marking auto mode.
module led_serializer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic            clk,
    input  logic            async_reset,
    led_serializer_if.slave bus
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [7:0]       shift_r;
    logic [3:0]       bits_left_r;
    logic [CNT_W-1:0] tick_cnt_r;

    logic             busy_s;
    logic             done_s;
    logic             bit_s;
    logic             tick_s;
    logic             step_s;

    // Digit pattern for the presented bit: "1" or "0", blank when not shifting.
    function automatic logic [6:0] seg_decode(input logic busy_v, input logic bit_v);
        logic [6:0] pattern;
        if (!busy_v) begin
            pattern = 7'b000_0000;
        end else if (bit_v) begin
            pattern = 7'b000_0110;
        end else begin
            pattern = 7'b011_1111;
        end
        return pattern;
    endfunction

    // Decode status from registered state and form the step event.
    always_comb begin
        busy_s = (state_r == ST_SHIFT);
        done_s = (state_r == ST_DONE);
        if (busy_s) begin
            bit_s = shift_r[7];
        end else begin
            bit_s = 1'b0;
        end
        // Tick only fires while shifting in auto mode; a coincident manual
        // pulse merges into the same single step.
        if (busy_s && bus.auto_en && (tick_cnt_r == TICK_MAX)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        step_s = bus.step_re | tick_s;
    end

    // Serializer FSM with shift register, bit counter and tick divider.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= 8'h00;
            bits_left_r <= 4'd0;
            tick_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tick_cnt_r <= '0;
                    if (bus.load_re) begin
                        shift_r     <= bus.switch_in;
                        bits_left_r <= 4'd8;
                        state_r     <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (bus.load_re) begin
                        // Reload wins over any step in the same cycle.
                        shift_r     <= bus.switch_in;
                        bits_left_r <= 4'd8;
                        tick_cnt_r  <= '0;
                    end else begin
                        if (!bus.auto_en || tick_s) begin
                            tick_cnt_r <= '0;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
                        end
                        if (step_s) begin
                            shift_r     <= {shift_r[6:0], 1'b0};
                            bits_left_r <= bits_left_r - 4'd1;
                            if (bits_left_r == 4'd1) begin
                                state_r <= ST_DONE;
                            end else begin
                                state_r <= ST_SHIFT;
                            end
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end
                end
                ST_DONE: begin
                    // Single-cycle completion; a load here is dropped.
                    tick_cnt_r <= '0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    shift_r     <= 8'h00;
                    bits_left_r <= 4'd0;
                    tick_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign bus.led_output     = shift_r;
    assign bus.bit_out        = bit_s;
    assign bus.bits_left      = bits_left_r;
    assign bus.busy           = busy_s;
    assign bus.done           = done_s;
    assign bus.segment_output = {busy_s & bus.auto_en, seg_decode(busy_s, bit_s)};

endmodule

// File: tb/tb_led_serializer.sv
// Self-checking bench for led_serializer with a small divider (TICK_DIV=4).
// A behavioural model tracks the word, remaining count and auto-step timing;
// directed tables and sequences cover the documented corner cases, then a
// randomized run compares every cycle against the model.
module tb_led_serializer;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic async_reset = 1'b0;
    always #5 clk = ~clk;

    led_serializer_if bus();

    led_serializer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .async_reset(async_reset),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    // Behavioural model: phase 0 = waiting, 1 = shifting, 2 = finished pulse
    int         m_phase;
    logic [7:0] m_word;
    int         m_left;
    int         m_age;   // consecutive auto-enabled shifting cycles since last step/load

    function void model_reset();
        m_phase = 0;
        m_word  = 8'h00;
        m_left  = 0;
        m_age   = 0;
    endfunction

    // Apply one clock edge with the inputs present at that edge.
    function void model_edge();
        bit tick;
        tick = 1'b0;
        if (m_phase == 0) begin
            if (bus.load_re) begin
                m_word = bus.switch_in; m_left = 8; m_age = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (bus.load_re) begin
                m_word = bus.switch_in; m_left = 8; m_age = 0;
            end else begin
                if (bus.auto_en) begin
                    m_age = m_age + 1;
                    if (m_age == TD) begin
                        tick = 1'b1;
                        m_age = 0;
                    end
                end else begin
                    m_age = 0;
                end
                if (bus.step_re || tick) begin
                    m_word = m_word << 1;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_age = 0;
                    end
                end
            end
        end else begin
            m_phase = 0;
        end
    endfunction

    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Compare every output against the model.
    task automatic check_model(input string name);
        logic [22:0] e;
        logic [22:0] a;
        logic        busy_e;
        logic        bit_e;
        logic [6:0]  seg_e;
        busy_e = (m_phase == 1);
        bit_e  = busy_e ? m_word[7] : 1'b0;
        seg_e  = !busy_e ? 7'h00 : (bit_e ? 7'h06 : 7'h3F);
        e = {m_word, bit_e, 4'(m_left), busy_e, (m_phase == 2), (busy_e & bus.auto_en), seg_e};
        a = {bus.led_output, bus.bit_out, bus.bits_left, bus.busy, bus.done, bus.segment_output};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got led=%h bit=%b left=%0d busy=%b done=%b seg=%h expected led=%h bit=%b left=%0d busy=%b done=%b seg=%h",
                     name, a[22:15], a[14], a[13:10], a[9], a[8], a[7:0],
                     e[22:15], e[14], e[13:10], e[9], e[8], e[7:0]);
        end
    endtask

    task automatic cyc(input string name);
        @(posedge clk);
        if (async_reset) model_edge();
        #1;
        if (bus.done) done_cnt++;
        check_model(name);
    endtask

    task automatic drive(input logic l, input logic s, input logic [7:0] sw, input string name);
        bus.load_re   = l;
        bus.step_re   = s;
        bus.switch_in = sw;
        cyc(name);
        bus.load_re = 1'b0;
        bus.step_re = 1'b0;
    endtask

    task automatic do_reset(input string name);
        #3;
        async_reset = 1'b0;
        model_reset();
        #1;
        check_model(name);
        cyc(name);
        cyc(name);
        #2;
        async_reset = 1'b1;
    endtask

    typedef struct {
        logic       l;
        logic       s;
        logic [7:0] sw;
        logic [7:0] e_led;
        logic [3:0] e_left;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl[16];
    logic [7:0] exp_led[9];
    logic       exp_bit[8];

    initial begin
        int n;
        bus.load_re = 1'b0; bus.step_re = 1'b0; bus.auto_en = 1'b0; bus.switch_in = 8'h00;
        model_reset();
        #12;
        chk("reset_led", bus.led_output, 8'h00);
        chk("reset_seg", bus.segment_output, 8'h00);
        check_model("reset_state");
        async_reset = 1'b1;

        // Directed table: reload priority, drain to zero, load ignored in done.
        tbl[0]  = '{1'b1, 1'b0, 8'h0F, 8'h0F, 4'd8, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h0F, 4'd8, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 8'h1E, 4'd7, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 8'h3C, 4'd6, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'h0F, 8'h0F, 4'd8, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 8'h1E, 4'd7, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'h3C, 4'd6, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h00, 8'h78, 4'd5, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'hF0, 4'd4, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 8'hE0, 4'd3, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 8'hC0, 4'd2, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 8'h80, 4'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 8'hAA, 8'h00, 4'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'h55, 8'h55, 4'd8, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].l, tbl[i].s, tbl[i].sw, "table_model");
            chk($sformatf("table_%0d", i),
                {bus.led_output, bus.bits_left, bus.busy, bus.done},
                {tbl[i].e_led, tbl[i].e_left, tbl[i].e_busy, tbl[i].e_done});
        end
        do_reset("table_reset");

        // A5 manual drain, steps spaced 3 cycles apart.
        exp_led[0] = 8'hA5; exp_led[1] = 8'h4A; exp_led[2] = 8'h94;
        exp_led[3] = 8'h28; exp_led[4] = 8'h50; exp_led[5] = 8'hA0;
        exp_led[6] = 8'h40; exp_led[7] = 8'h80; exp_led[8] = 8'h00;
        exp_bit[0] = 1'b1; exp_bit[1] = 1'b0; exp_bit[2] = 1'b1; exp_bit[3] = 1'b0;
        exp_bit[4] = 1'b0; exp_bit[5] = 1'b1; exp_bit[6] = 1'b0; exp_bit[7] = 1'b1;
        done_cnt = 0;
        drive(1'b1, 1'b0, 8'hA5, "a5_load");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_bit_%0d", i), bus.bit_out, exp_bit[i]);
            chk($sformatf("a5_led_%0d", i), bus.led_output, exp_led[i]);
            drive(1'b0, 1'b1, 8'h00, "a5_step");
            cyc("a5_gap");
            cyc("a5_gap");
        end
        chk("a5_led_end", bus.led_output, exp_led[8]);
        chk("a5_done_count", done_cnt, 1);
        chk("a5_busy_end", bus.busy, 0);

        // Automatic stepping of FF: done after 8 ticks of TD cycles.
        bus.auto_en = 1'b1;
        drive(1'b1, 1'b0, 8'hFF, "auto_load");
        chk("auto_seg", bus.segment_output, 8'b1000_0110);
        n = 0;
        while (!bus.done && n < 100) begin
            cyc("auto_run");
            n++;
        end
        chk("auto_done_latency", n, 8 * TD);
        cyc("auto_after");
        chk("auto_seg_idle", bus.segment_output, 8'h00);

        // Manual step coincident with a tick counts once; tick phase keeps going.
        drive(1'b1, 1'b0, 8'h3C, "coin_load");
        cyc("coin_wait"); cyc("coin_wait"); cyc("coin_wait");
        drive(1'b0, 1'b1, 8'h00, "coin_step");
        chk("coin_left", bus.bits_left, 7);
        cyc("coin_wait"); cyc("coin_wait"); cyc("coin_wait"); cyc("coin_wait");
        chk("coin_next_tick", bus.bits_left, 6);
        bus.auto_en = 1'b0;

        // Reset mid-serialization aborts without a done pulse.
        drive(1'b1, 1'b0, 8'h81, "abort_load");
        drive(1'b0, 1'b1, 8'h00, "abort_step");
        drive(1'b0, 1'b1, 8'h00, "abort_step");
        drive(1'b0, 1'b1, 8'h00, "abort_step");
        done_cnt = 0;
        do_reset("abort_reset");
        chk("abort_led", bus.led_output, 8'h00);
        cyc("abort_idle");
        cyc("abort_idle");
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_busy", bus.busy, 0);

        // Idle ignores steps and auto mode.
        bus.auto_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'(i % 2), 8'h5A, "idle_ignore");
        end
        chk("idle_seg", bus.segment_output, 8'h00);
        chk("idle_left", bus.bits_left, 0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rand_reset");
            end else begin
                drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                      8'($urandom), "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
